instr_block_memory: RTL

- Instruction-memory responder: the slave end of the instruction cache's block-refill interface.
- 1024-byte array, organised as 64 blocks of 16 bytes.
- Returns one 128-bit block per request after a fixed multi-cycle latency, holding busywait high throughout.
- A word-wide load port initialises program contents from the bench or boot logic.

---
 rtl/instr_block_memory.sv | 112 +++++++++++
 1 files changed

// File: rtl/instr_block_memory.sv
// Instruction-memory responder for the instruction cache's block-refill port.
// Holds 64 blocks of 16 bytes. A request is answered with one 128-bit block
// after READ_LATENCY clock edges. A word-wide load port fills in the program.
module instr_block_memory #(
    parameter int READ_LATENCY = 40,
    parameter int CNT_W        = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [5:0]   address,
    output logic [127:0] readdata,
    output logic         busywait,
    input  logic         load_en,
    input  logic [7:0]   load_addr,
    input  logic [31:0]  load_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Edges still to wait after acceptance before the block is returned.
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LATENCY - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [5:0]       block_addr;
    logic [5:0]       block_addr_next;
    logic             capture;
    logic [127:0]     block_data;

    // Stored as 256 little-endian words. Word w holds bytes 4w..4w+3, so
    // block b is words 4b..4b+3, with the lowest word in the lowest bits.
    logic [31:0] mem [0:255];

    assign block_data = {mem[{block_addr, 2'd3}], mem[{block_addr, 2'd2}],
                         mem[{block_addr, 2'd1}], mem[{block_addr, 2'd0}]};

    // Next-state, latency counting and busywait decoding.
    always_comb begin
        state_next      = state;
        count_next      = count;
        block_addr_next = block_addr;
        capture         = 1'b0;
        busywait        = 1'b0;
        case (state)
            IDLE: begin
                // Raised in the same cycle as read, so the cache never
                // sees a low busywait before the request is accepted.
                busywait = read;
                if (read) begin
                    block_addr_next = address;
                    count_next      = LAT_M1;
                    state_next      = BUSY;
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (!read) begin
                    // The cache withdrew the request, so drop it.
                    state_next = IDLE;
                end else if (count == '0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            DONE: begin
                // One cycle with busywait low lets the cache see completion.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state and returned block. Reset drops any pending request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            readdata <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (capture) begin
                readdata <= block_data;
            end
        end
    end

    // Latched block address. It is only used while a request is in flight.
    always_ff @(posedge clock) begin
        block_addr <= block_addr_next;
    end

    // Initialisation writes. The array is never cleared. A write on the same
    // edge as a completion is seen only by later reads.
    always_ff @(posedge clock) begin
        if (load_en && !reset) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule
